// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/serial_fa_cell.sv
// Single-bit full adder used by the serial adder datapath.
module serial_fa_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   // sum and carry of one bit position
   always_comb begin
      s  = a ^ b ^ ci;
      co = (a & b) | (a & ci) | (b & ci);
   end

endmodule

// File: rtl/serial_adder_seq.sv
// Bit-serial adder: one full-adder cell processes one bit per SHIFT cycle,
// LSB first; the result is published on entry to DONE.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the signed-overflow
// output ovf.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// SHIFT | WIDTH cycles, one result bit per cycle, busy=1
// DONE  | one cycle, done=1, sum/cout valid; returns to IDLE
module serial_adder_seq
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = $clog2(WIDTH + 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_carry;
   // holds the WIDTH-1 result bits produced so far; the last bit comes
   // straight from the cell on the final step
   logic [WIDTH-2:0] r_res;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             w_s;
   logic             w_co;
   logic             w_last;
   logic [WIDTH-1:0] w_cat;

   serial_fa_cell u_fa (
      .a  (r_a[0]),
      .b  (r_b[0]),
      .ci (r_carry),
      .s  (w_s),
      .co (w_co)
   );

   assign w_last = (r_cnt == CW'(WIDTH - 1));
   assign w_cat  = {w_s, r_res};
   assign sum    = r_sum;
   assign cout   = r_cout;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // next-state and status outputs
   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) w_state_nxt = SHIFT;
         end
         SHIFT: begin
            busy = 1'b1;
            if (w_last) w_state_nxt = DONE;
         end
         DONE: begin
            done        = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // operand capture, per-bit shift/carry update and result publication
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_carry <= 1'b0;
         r_res   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_carry <= cin;
                  r_cnt   <= '0;
               end
            end
            SHIFT: begin
               r_a     <= r_a >> 1;
               r_b     <= r_b >> 1;
               r_carry <= w_co;
               r_res   <= w_cat[WIDTH-1:1];
               r_cnt   <= r_cnt + CW'(1);
               if (w_last) begin
                  r_sum  <= w_cat;
                  r_cout <= w_co;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef SERIAL_ADDER_OVF_EN
   logic r_ovf;

   assign ovf = r_ovf;

   // signed overflow: carry into the MSB differs from carry out of it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (r_state == SHIFT && w_last) begin
         r_ovf <= r_carry ^ w_co;
      end
   end
`endif

endmodule

// File: tb/tb_serial_adder_seq.sv
// Scoreboard bench for serial_adder_seq (WIDTH=8): expected results are
// queued at each accepted start and checked when done is seen.
module tb_serial_adder_seq;

   localparam int W = 8;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         cin   = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic         ovf;
`endif

   serial_adder_seq #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [W:0] cs;
      logic       ov;
      int         due;
   } exp_t;

   exp_t       sb[$];
   exp_t       mon_e;
   int         last_acc = -100;
   logic [W:0] held_cs  = '0;
   logic       held_ov  = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h cycle=%0d", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      int s;
      s = int'(x) + int'(y) + int'(c);
      return (W+1)'(s);
   endfunction

   function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
      int s;
      s = int'($signed(x)) + int'($signed(y)) + int'(c);
      return (s > (2**(W-1)) - 1) || (s < -(2**(W-1)));
   endfunction

   // called #1 after an edge the bench's timing model says accepted start
   task automatic accept();
      exp_t e;
      e.cs     = ref_add(a, b, cin);
      e.ov     = ref_ovf(a, b, cin);
      e.due    = cyc + W;
      last_acc = cyc;
      sb.push_back(e);
   endtask

   task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
      @(negedge clk);
      a = ia; b = ib; cin = ic; start = 1'b1;
      @(posedge clk); #1;
      accept();
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom()); b = W'($urandom()); cin = 1'($urandom());
      repeat (W + 1) @(negedge clk);
   endtask

   // monitor: checks busy window, done timing, result and hold behaviour
   always @(negedge clk) begin
      if (rst_n) begin
         if (sb.size() > 0 && sb[0].due < cyc) begin
            checks++;
            failures++;
            $display("FAIL missing_done actual=none required_cycle=%0d cycle=%0d", sb[0].due, cyc);
            void'(sb.pop_front());
         end
         chk("busy", 32'(busy), 32'(cyc >= last_acc && cyc < last_acc + W));
         if (done) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL spurious_done actual=1 expected=0 cycle=%0d", cyc);
            end else begin
               mon_e = sb.pop_front();
               chk("done_latency", 32'(cyc), 32'(mon_e.due));
               chk("result", 32'({cout, sum}), 32'(mon_e.cs));
`ifdef SERIAL_ADDER_OVF_EN
               chk("ovf", 32'(ovf), 32'(mon_e.ov));
`endif
               held_cs = mon_e.cs;
               held_ov = mon_e.ov;
            end
         end else begin
            chk("held_result", 32'({cout, sum}), 32'(held_cs));
`ifdef SERIAL_ADDER_OVF_EN
            chk("held_ovf", 32'(ovf), 32'(held_ov));
`endif
         end
      end
   end

   initial begin
      int ops;
      int guard;

      #2 rst_n = 1'b0;
      #2;
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_sum", 32'(sum), 32'(0));
      chk("rst_cout", 32'(cout), 32'(0));
`ifdef SERIAL_ADDER_OVF_EN
      chk("rst_ovf", 32'(ovf), 32'(0));
`endif
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;

      do_op(8'h0F, 8'h01, 1'b0);
      do_op(8'hFF, 8'h01, 1'b0);
      do_op(8'h00, 8'h00, 1'b1);
      do_op(8'h7F, 8'h01, 1'b0);
      do_op(8'hFF, 8'hFF, 1'b1);
      do_op(8'h80, 8'h80, 1'b0);

      // start re-pulsed during SHIFT must be ignored
      @(negedge clk);
      a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      accept();
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      start = 1'b1; a = 8'hFF;
      @(negedge clk);
      start = 1'b0;
      repeat (W + 6) @(negedge clk);

      // reset in SHIFT cycle 4 aborts the operation
      @(negedge clk);
      a = 8'h55; b = 8'h22; cin = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      accept();
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'(0));
      chk("abort_done", 32'(done), 32'(0));
      chk("abort_sum", 32'(sum), 32'(0));
      chk("abort_cout", 32'(cout), 32'(0));
      sb.delete();
      last_acc = -100;
      held_cs  = '0;
      held_ov  = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      do_op(8'h01, 8'h02, 1'b0);

      // back-to-back random: start held high, inputs change every cycle
      ops   = 0;
      guard = 0;
      while (ops < 30 && guard < 2000) begin
         @(negedge clk);
         a = W'($urandom()); b = W'($urandom()); cin = 1'($urandom()); start = 1'b1;
         @(posedge clk); #1;
         if (cyc >= last_acc + W + 2) begin
            accept();
            ops++;
         end
         guard++;
      end
      @(negedge clk);
      start = 1'b0;
      repeat (W + 4) @(negedge clk);
      chk("queue_drained", 32'(sb.size()), 32'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_adder_seq.md
SERIAL_ADDER_SEQ -- requirements
Module: serial_adder_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  sole clock, rising-edge active.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  request to begin an addition; sampled in IDLE only.
REQ-005 SHALL have port a  input  WIDTH  operand A; captured on the accepting edge.
REQ-006 SHALL have port b  input  WIDTH  operand B; captured on the accepting edge.
REQ-007 SHALL have port cin  input  1  carry-in; captured on the accepting edge.
REQ-008 SHALL have port busy  output  1  high while in the SHIFT state.
REQ-009 SHALL have port done  output  1  one-cycle pulse when the result becomes valid.
REQ-010 SHALL have port sum  output  WIDTH  result; held stable from done until the next accepted start.
REQ-011 SHALL have port cout  output  1  final carry-out; same validity as sum.

Function
REQ-012 SHALL implement a three-state FSM with states IDLE, SHIFT and DONE, all registered.
REQ-013 IDLE with start=1 at an edge SHALL load a, b and cin into internal registers, clear the bit counter and go to SHIFT.
REQ-014 Each SHIFT cycle SHALL add operand-register LSBs plus the carry register through one full-adder cell, shift the sum bit into the result register MSB, right-shift both operand registers and update the carry register.
REQ-015 SHIFT SHALL last exactly WIDTH cycles, counted by a $clog2(WIDTH+1)-bit counter, then go to DONE.
REQ-016 DONE SHALL last one cycle with done=1, then return to IDLE unconditionally.
REQ-017 Latency: done SHALL be high in the WIDTH+1th cycle after the accepting edge (cycle 9 for WIDTH=8).
REQ-018 sum and cout SHALL update only on entry to DONE; intermediate shift values SHALL NOT appear on sum or cout.
REQ-019 start while in SHIFT or DONE SHALL be ignored, with no queuing.
REQ-020 Changes to a, b or cin after the accepting edge SHALL NOT affect the result.
REQ-021 Arithmetic SHALL be unsigned modulo 2^WIDTH, with the carry out of bit WIDTH-1 reported on cout.

Reset
REQ-022 rst_n low SHALL force, asynchronously, state=IDLE, busy=0, done=0, sum=0, cout=0, counter=0, carry=0 and operand registers=0.
REQ-023 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse; the first start after release SHALL begin a fresh addition.

Configuration
REQ-024 Macro SERIAL_ADDER_OVF_EN defined SHALL add output port ovf  output  1, the two's-complement signed overflow (carry into MSB XOR carry out of MSB), with the same validity and reset value 0 as cout.
REQ-025 With SERIAL_ADDER_OVF_EN undefined, the ovf port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-026 A shared package serial_adder_pkg SHALL hold the FSM state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
REQ-027 The single-bit add SHALL be a separate sub-module, serial_fa_cell (inputs a, b, ci; outputs s, co), zero-delay combinational, instantiated once.
REQ-028 The remainder (FSM, counter, shift/carry registers) SHALL be in serial_adder_seq itself.

Verification (WIDTH=8)
REQ-029 a=0x0F, b=0x01, cin=0, start pulse -> busy high for 8 cycles, done in cycle 9, sum=0x10, cout=0.
REQ-030 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
REQ-031 Start accepted with a=0x12, b=0x34; start re-pulsed in SHIFT cycle 3 with a=0xFF -> one done only, sum=0x46; no second operation follows.
REQ-032 rst_n asserted in SHIFT cycle 4 -> busy, done, sum and cout are 0 immediately; no done pulse; next start with a=0x01, b=0x02 -> sum=0x03.
REQ-033 With SERIAL_ADDER_OVF_EN defined: 0x7F+0x01 -> sum=0x80, ovf=1, cout=0; 0xFF+0x01 -> ovf=0, cout=1.
REQ-034 Randomised back-to-back operations (start asserted in every IDLE cycle) -> every {cout,sum} equals a+b+cin, checked against a reference model.
